ps2_key_decoder: RTL and testbench
==================================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have `clk`, input, 1 bit: the system clock; all state changes on its rising edge.
REQ-002 SHALL have `reset`, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have `ps2_ready`, input, 1 bit: the upstream receiver FIFO is non-empty.
REQ-004 SHALL have `ps2_data`, input, 8 bits: the scan code at the head of the upstream FIFO.
REQ-005 SHALL have `ps2_overflow`, input, 1 bit: the upstream FIFO has overflowed.
REQ-006 SHALL have `ps2_nextdata_n`, output, 1 bit: active-low pop request to the upstream FIFO.
REQ-007 SHALL have `key_code`, output, 8 bits: make code of the key currently held.
REQ-008 SHALL have `key_ext`, output, 1 bit: the held key had an E0 prefix.
REQ-009 SHALL have `key_ascii`, output, 8 bits: ASCII value of `key_code`; 00 when unmapped or extended.
REQ-010 SHALL have `key_valid`, output, 1 bit: a key is held; doubles as the display enable.
REQ-011 SHALL have `key_pressed`, output, 1 bit: one-cycle pulse on each new make event.
REQ-012 SHALL have `key_released`, output, 1 bit: one-cycle pulse on each break event.
REQ-013 SHALL have `press_count`, output, 8 bits: count of new key presses.
REQ-014 SHALL have `err_overflow`, output, 1 bit: sticky copy of `ps2_overflow`.

Function
REQ-015 SHALL implement the fetch FSM IDLE -> ACK -> SETTLE -> IDLE.
- IDLE: when `ps2_ready`=1, capture `ps2_data`, decode it, go to ACK.
- ACK: drive `ps2_nextdata_n`=0 for exactly one cycle.
- SETTLE: drive `ps2_nextdata_n`=1 for one cycle so the upstream `ready` can update.
REQ-016 SHALL pop exactly one byte per capture, keep `ps2_nextdata_n`=1 outside ACK, and never pop while `ps2_ready`=0; maximum throughput is one byte per 3 cycles.
REQ-017 SHALL keep the prefix flags `brk` and `ext`.
- Byte E0: set `ext`; no event.
- Byte F0: set `brk`; no event.
- Both flags clear after any other byte.
REQ-018 SHALL treat a non-prefix byte with `brk`=1 as a break.
- Pulse `key_released`.
- Clear `key_valid` only if the byte equals `key_code` and `ext` equals `key_ext`; otherwise hold `key_valid`.
REQ-019 SHALL treat a non-prefix byte with `brk`=0 that matches the held key (`key_valid`=1, same code, same `ext`) as typematic repeat: no pulse, no count change.
REQ-020 SHALL treat any other non-prefix byte with `brk`=0 as a new make.
- Load `key_code`, `key_ext` and `key_ascii`.
- Set `key_valid`.
- Pulse `key_pressed`.
- Increment `press_count`, wrapping FF -> 00.
REQ-021 SHALL update all decode outputs and pulses on the clock edge that captures the byte, giving zero added latency after capture.
REQ-022 SHALL map make codes to ASCII as follows:
- Letters A-Z to 41-5A (e.g. 1C -> 41, 32 -> 42, 21 -> 43).
- Digits to 30-39 (45 -> 30, 16 -> 31).
- 29 -> 20 (space); 5A -> 0D (Enter).
- All other codes, and any code with `ext`=1, -> 00.
REQ-023 SHALL set `err_overflow` when `ps2_overflow`=1 and hold it until reset; the overflow SHALL NOT affect decoding.

Reset
REQ-024 SHALL, when `reset` is high on a clock edge, return the FSM to IDLE, clear `brk`/`ext`, drive `ps2_nextdata_n`=1 and set every other output to 0.
REQ-025 SHALL give reset priority over any capture or pop on the same edge; a reset during ACK or SETTLE abandons that pop.

Structure
REQ-026 SHALL place the FSM state encoding and the prefix constants E0 and F0 in the shared package `ps2_pkg`.
REQ-027 SHALL implement the ASCII table as the combinational 256-entry sub-module `scancode_ascii_rom`, indexed by the captured byte.

Verification
REQ-028 SHALL cover press and release: bytes 1C, F0, 1C -> `key_code`=1C, `key_ascii`=41, `key_valid` 1 then 0, `press_count`=1, one pulse each on `key_pressed` and `key_released`.
REQ-029 SHALL cover typematic repeat: bytes 1C, 1C, 1C -> `press_count`=1 and a single `key_pressed` pulse.
REQ-030 SHALL cover an extended key: bytes E0, 75 -> `key_ext`=1, `key_ascii`=00, `key_valid`=1; then E0, F0, 75 -> `key_valid`=0.
REQ-031 SHALL cover the handshake: 8 queued bytes -> exactly 8 `ps2_nextdata_n` low pulses, each one cycle wide and at least 3 cycles apart, and none while `ps2_ready`=0.
REQ-032 SHALL cover count wrap: 256 alternating makes 1C/32, each followed by its break -> `press_count` wraps from FF to 00.
REQ-033 SHALL cover reset mid-sequence: F0, then reset, then 1C -> treated as a make, `key_valid`=1, `press_count`=1.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key decoder: fetch FSM encoding and prefix bytes.
package ps2_pkg;

  // Fetch handshake with the upstream receiver FIFO.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACK    = 2'd1,
    ST_SETTLE = 2'd2
  } fetch_st_e;

  // Scan code set 2 prefix bytes.
  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Bus bundle between the PS/2 receiver FIFO, the key decoder and its consumers.
interface ps2_key_decoder_if;
  import ps2_pkg::*;

  // upstream FIFO side
  logic       ps2_ready;
  logic [7:0] ps2_data;
  logic       ps2_overflow;
  logic       ps2_nextdata_n;
  // decoded key side
  logic [7:0] key_code;
  logic       key_ext;
  logic [7:0] key_ascii;
  logic       key_valid;
  logic       key_pressed;
  logic       key_released;
  logic [7:0] press_count;
  logic       err_overflow;

  // decoder view
  modport slave (
    input  ps2_ready, ps2_data, ps2_overflow,
    output ps2_nextdata_n, key_code, key_ext, key_ascii, key_valid,
           key_pressed, key_released, press_count, err_overflow
  );

  // FIFO / consumer view
  modport master (
    output ps2_ready, ps2_data, ps2_overflow,
    input  ps2_nextdata_n, key_code, key_ext, key_ascii, key_valid,
           key_pressed, key_released, press_count, err_overflow
  );

endinterface

// File: rtl/scancode_ascii_rom.sv
// Combinational scan code set 2 make code -> ASCII table; unmapped codes give 00.
module scancode_ascii_rom (
  input  logic [7:0] i_code,
  output logic [7:0] o_ascii
);

  // table lookup, default 00 covers every unlisted entry
  always_comb begin
    o_ascii = 8'h00;
    case (i_code)
      8'h1C: o_ascii = 8'h41; // A
      8'h32: o_ascii = 8'h42; // B
      8'h21: o_ascii = 8'h43; // C
      8'h23: o_ascii = 8'h44; // D
      8'h24: o_ascii = 8'h45; // E
      8'h2B: o_ascii = 8'h46; // F
      8'h34: o_ascii = 8'h47; // G
      8'h33: o_ascii = 8'h48; // H
      8'h43: o_ascii = 8'h49; // I
      8'h3B: o_ascii = 8'h4A; // J
      8'h42: o_ascii = 8'h4B; // K
      8'h4B: o_ascii = 8'h4C; // L
      8'h3A: o_ascii = 8'h4D; // M
      8'h31: o_ascii = 8'h4E; // N
      8'h44: o_ascii = 8'h4F; // O
      8'h4D: o_ascii = 8'h50; // P
      8'h15: o_ascii = 8'h51; // Q
      8'h2D: o_ascii = 8'h52; // R
      8'h1B: o_ascii = 8'h53; // S
      8'h2C: o_ascii = 8'h54; // T
      8'h3C: o_ascii = 8'h55; // U
      8'h2A: o_ascii = 8'h56; // V
      8'h1D: o_ascii = 8'h57; // W
      8'h22: o_ascii = 8'h58; // X
      8'h35: o_ascii = 8'h59; // Y
      8'h1A: o_ascii = 8'h5A; // Z
      8'h45: o_ascii = 8'h30; // 0
      8'h16: o_ascii = 8'h31; // 1
      8'h1E: o_ascii = 8'h32; // 2
      8'h26: o_ascii = 8'h33; // 3
      8'h25: o_ascii = 8'h34; // 4
      8'h2E: o_ascii = 8'h35; // 5
      8'h36: o_ascii = 8'h36; // 6
      8'h3D: o_ascii = 8'h37; // 7
      8'h3E: o_ascii = 8'h38; // 8
      8'h46: o_ascii = 8'h39; // 9
      8'h29: o_ascii = 8'h20; // space
      8'h5A: o_ascii = 8'h0D; // enter
      default: o_ascii = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 key decoder: pops scan codes from the receiver FIFO, tracks E0/F0
// prefixes and presents the currently held key with press/release pulses.
module ps2_key_decoder
  import ps2_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  ps2_key_decoder_if.slave   bus
);

  fetch_st_e  r_state, w_state_nxt;
  logic       w_capture;
  logic       w_nextdata_n;

  logic       r_brk, r_ext;
  logic [7:0] r_key_code;
  logic       r_key_ext;
  logic [7:0] r_key_ascii;
  logic       r_key_valid;
  logic       r_pressed, r_released;
  logic [7:0] r_press_count;
  logic       r_err_overflow;

  logic [7:0] w_rom_ascii;
  logic       w_match;

  scancode_ascii_rom u_rom (
    .i_code  (bus.ps2_data),
    .o_ascii (w_rom_ascii)
  );

  // incoming byte names the held key (same code, same prefix)
  assign w_match = (bus.ps2_data == r_key_code) && (r_ext == r_key_ext);

  // fetch FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // fetch FSM next state: capture in IDLE, pop for one cycle, then let ready settle
  always_comb begin
    w_state_nxt  = r_state;
    w_nextdata_n = 1'b1;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.ps2_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        w_nextdata_n = 1'b0;
        w_state_nxt  = ST_SETTLE;
      end
      ST_SETTLE: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // decode captured byte into key state, pulses and counters on the capture edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_brk          <= 1'b0;
      r_ext          <= 1'b0;
      r_key_code     <= 8'h00;
      r_key_ext      <= 1'b0;
      r_key_ascii    <= 8'h00;
      r_key_valid    <= 1'b0;
      r_pressed      <= 1'b0;
      r_released     <= 1'b0;
      r_press_count  <= 8'h00;
      r_err_overflow <= 1'b0;
    end else begin
      r_pressed  <= 1'b0;
      r_released <= 1'b0;
      if (bus.ps2_overflow) r_err_overflow <= 1'b1;
      if (w_capture) begin
        if (bus.ps2_data == SC_EXT) begin
          r_ext <= 1'b1;
        end else if (bus.ps2_data == SC_BRK) begin
          r_brk <= 1'b1;
        end else begin
          r_brk <= 1'b0;
          r_ext <= 1'b0;
          if (r_brk) begin
            // break of some key; only the held key drops key_valid
            r_released <= 1'b1;
            if (w_match) r_key_valid <= 1'b0;
          end else if (!(r_key_valid && w_match)) begin
            // new make (a matching make while held is typematic and ignored)
            r_key_code    <= bus.ps2_data;
            r_key_ext     <= r_ext;
            r_key_ascii   <= r_ext ? 8'h00 : w_rom_ascii;
            r_key_valid   <= 1'b1;
            r_pressed     <= 1'b1;
            r_press_count <= r_press_count + 8'd1;
          end
        end
      end
    end
  end

  assign bus.ps2_nextdata_n = w_nextdata_n;
  assign bus.key_code       = r_key_code;
  assign bus.key_ext        = r_key_ext;
  assign bus.key_ascii      = r_key_ascii;
  assign bus.key_valid      = r_key_valid;
  assign bus.key_pressed    = r_pressed;
  assign bus.key_released   = r_released;
  assign bus.press_count    = r_press_count;
  assign bus.err_overflow   = r_err_overflow;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder with a queue model of the upstream FIFO.
module tb_ps2_key_decoder;
  logic clk;
  logic reset;

  ps2_key_decoder_if u_if ();

  ps2_key_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q[$];
  int n_press = 0, n_rel = 0, n_pop = 0, n_badpop = 0, n_wide = 0, n_close = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // FIFO model and monitor: sample mid-cycle, pop on an active-low request
  initial begin
    int cyc = 0;
    int last_pop = -100;
    logic prev_low = 1'b0;
    u_if.ps2_ready = 1'b0;
    u_if.ps2_data  = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (u_if.key_pressed === 1'b1)  n_press++;
      if (u_if.key_released === 1'b1) n_rel++;
      if (u_if.ps2_nextdata_n === 1'b0) begin
        n_pop++;
        if (!u_if.ps2_ready) n_badpop++;
        if (prev_low) n_wide++;
        if (cyc - last_pop < 3) n_close++;
        last_pop = cyc;
        if (q.size() != 0) void'(q.pop_front());
      end
      prev_low = (u_if.ps2_nextdata_n === 1'b0);
      u_if.ps2_ready = (q.size() != 0);
      u_if.ps2_data  = (q.size() != 0) ? q[0] : 8'h00;
    end
  end

  task automatic push(input logic [7:0] b);
    q.push_back(b);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  logic [7:0] tbl_code [6] = '{8'h32, 8'h21, 8'h45, 8'h29, 8'h5A, 8'h0E};
  logic [7:0] tbl_asc  [6] = '{8'h42, 8'h43, 8'h30, 8'h20, 8'h0D, 8'h00};
  logic [7:0] hs_bytes [8] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};

  initial begin
    int p0, r0, pop0, bad0;
    logic [7:0] c;
    reset = 1'b1;
    u_if.ps2_overflow = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    chk("rst_nextdata_n", u_if.ps2_nextdata_n, 1);
    chk("rst_valid", u_if.key_valid, 0);
    chk("rst_code", u_if.key_code, 0);
    chk("rst_ascii", u_if.key_ascii, 0);
    chk("rst_count", u_if.press_count, 0);
    chk("rst_err", u_if.err_overflow, 0);

    // press A
    p0 = n_press;
    push(8'h1C); wait_idle();
    chk("make_code", u_if.key_code, 8'h1C);
    chk("make_ascii", u_if.key_ascii, 8'h41);
    chk("make_valid", u_if.key_valid, 1);
    chk("make_count", u_if.press_count, 1);
    chk("make_pulse", n_press - p0, 1);

    // release A
    r0 = n_rel; p0 = n_press;
    push(8'hF0); push(8'h1C); wait_idle();
    chk("brk_valid", u_if.key_valid, 0);
    chk("brk_pulse", n_rel - r0, 1);
    chk("brk_nopress", n_press - p0, 0);
    chk("brk_count", u_if.press_count, 1);

    // typematic
    p0 = n_press;
    push(8'h1C); push(8'h1C); push(8'h1C); wait_idle();
    chk("rep_count", u_if.press_count, 2);
    chk("rep_pulse", n_press - p0, 1);

    // break of a different key keeps A held
    r0 = n_rel;
    push(8'hF0); push(8'h32); wait_idle();
    chk("oth_brk_valid", u_if.key_valid, 1);
    chk("oth_brk_code", u_if.key_code, 8'h1C);
    chk("oth_brk_pulse", n_rel - r0, 1);
    push(8'hF0); push(8'h1C); wait_idle();
    chk("rel_a_valid", u_if.key_valid, 0);

    // extended key
    push(8'hE0); push(8'h75); wait_idle();
    chk("ext_flag", u_if.key_ext, 1);
    chk("ext_ascii", u_if.key_ascii, 0);
    chk("ext_valid", u_if.key_valid, 1);
    chk("ext_code", u_if.key_code, 8'h75);
    chk("ext_count", u_if.press_count, 3);
    r0 = n_rel;
    push(8'hE0); push(8'hF0); push(8'h75); wait_idle();
    chk("ext_brk_valid", u_if.key_valid, 0);
    chk("ext_brk_pulse", n_rel - r0, 1);

    // ascii table spot checks
    for (int i = 0; i < 6; i++) begin
      push(tbl_code[i]); wait_idle();
      chk($sformatf("ascii_%02h", tbl_code[i]), u_if.key_ascii, tbl_asc[i]);
    end
    chk("tbl_count", u_if.press_count, 9);

    // handshake: 8 queued bytes
    p0 = n_press; pop0 = n_pop; bad0 = n_badpop;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) push(hs_bytes[i]);
    wait_idle();
    chk("hs_pops", n_pop - pop0, 8);
    chk("hs_wide", n_wide, 0);
    chk("hs_close", n_close, 0);
    chk("hs_press", n_press - p0, 8);
    chk("hs_ascii", u_if.key_ascii, 8'h38);
    chk("hs_count", u_if.press_count, 17);
    pop0 = n_pop;
    repeat (10) @(posedge clk); #1;
    chk("hs_idle_pops", n_pop - pop0, 0);
    chk("hs_badpop", n_badpop - bad0, 0);

    // overflow is sticky and does not disturb decoding
    u_if.ps2_overflow = 1'b1;
    @(posedge clk); #1 u_if.ps2_overflow = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("ovf_sticky", u_if.err_overflow, 1);
    push(8'hF0); push(8'h3E); wait_idle();
    chk("ovf_decode", u_if.key_valid, 0);

    // count wrap
    do_reset();
    chk("wrap_rst_count", u_if.press_count, 0);
    chk("wrap_rst_err", u_if.err_overflow, 0);
    for (int i = 0; i < 256; i++) begin
      c = (i % 2 == 1) ? 8'h32 : 8'h1C;
      push(c); push(8'hF0); push(c); wait_idle();
      if (i == 254) chk("wrap_ff", u_if.press_count, 8'hFF);
    end
    chk("wrap_00", u_if.press_count, 8'h00);
    chk("wrap_valid", u_if.key_valid, 0);

    // reset between F0 and the key byte
    push(8'hF0); wait_idle();
    do_reset();
    p0 = n_press;
    push(8'h1C); wait_idle();
    chk("rstmid_valid", u_if.key_valid, 1);
    chk("rstmid_count", u_if.press_count, 1);
    chk("rstmid_pulse", n_press - p0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
